// File: rtl/apb_mat_slave.sv
// APB register slave for a small matrix engine. Holds operand rows, a control
// word, overflow flags and a flop scratchpad filled from engine results.
// The APB handshake and the engine sequence run as two parallel state registers
// that share one state encoding.

// Byte-lane strobed update of one operand row.
module apb_mat_row_wr #(
    parameter int DW      = 8,
    parameter int MAX_DIM = 4
) (
    input  logic [DW*MAX_DIM-1:0] old_i,
    input  logic [DW*MAX_DIM-1:0] wdata_i,
    input  logic [MAX_DIM-1:0]    strb_i,
    input  logic                  we_i,
    output logic [DW*MAX_DIM-1:0] new_o
);
    for (genvar j = 0; j < MAX_DIM; j++) begin : g_lane
        assign new_o[j*DW +: DW] = (we_i && strb_i[j]) ? wdata_i[j*DW +: DW] : old_i[j*DW +: DW];
    end
endmodule

module apb_mat_slave #(
    parameter int  DW      = 8,
    parameter int  BW      = 32,
    parameter int  ADDR_W  = 16,
    parameter int  SPN     = 4,
    localparam int MAX_DIM = BW / DW,
    localparam int E       = MAX_DIM * MAX_DIM
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [MAX_DIM-1:0]    pstrb_i,
    input  logic [BW-1:0]         pwdata_i,
    input  logic [ADDR_W-1:0]     paddr_i,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [BW-1:0]         prdata_o,
    input  logic                  done_i,
    input  logic [E-1:0]          of_i,
    input  logic [BW*E-1:0]       result_i,
    output logic [BW*MAX_DIM-1:0] operand_A_o,
    output logic [BW*MAX_DIM-1:0] operand_B_o,
    output logic [BW*E-1:0]       operand_C_o,
    output logic [15:0]           control_reg_o,
    output logic                  busy_o
);
    localparam int CW = $clog2(E) + 1;

    localparam logic [4:0] OFF_CTRL = 5'h00;
    localparam logic [4:0] OFF_A    = 5'h04;
    localparam logic [4:0] OFF_B    = 5'h08;
    localparam logic [4:0] OFF_FLAG = 5'h0C;
    localparam logic [4:0] OFF_SP   = 5'h10;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_OPERATE, S_SAVE} state_e;

    state_e apb_q, apb_d, eng_q, eng_d;

    logic                           pready_q, pready_d;
    logic                           pslverr_q, pslverr_d;
    logic [BW-1:0]                  prdata_q, prdata_d;

    logic [MAX_DIM-1:0][BW-1:0]     a_q, a_d, b_q, b_d;
    logic [SPN-1:0][E-1:0][BW-1:0]  sp_q, sp_d;
    logic [E-1:0][BW-1:0]           res_q, res_d;
    logic [E-1:0]                   of_cap_q, of_cap_d;
    logic [E-1:0]                   flags_q, flags_d;
    logic [15:0]                    ctrl_q, ctrl_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           busy_q, busy_d;

    logic [4:0]                     off;
    logic [1:0]                     row;
    logic [3:0]                     elem;
    logic [1:0]                     tgt;
    logic                           row_ok, elem_ok, tgt_ok;
    logic                           acc_err;
    logic                           sp_rd;
    logic [BW-1:0]                  rd_data;
    logic [BW-1:0]                  rsp_data;
    logic                           wr_commit, ctrl_we, a_we, b_we;
    logic [E-1:0][BW-1:0]           c_sel;
    logic                           unused_ok;

    assign off     = paddr_i[4:0];
    assign row     = paddr_i[6:5];
    assign elem    = paddr_i[8:5];
    assign tgt     = paddr_i[10:9];
    assign row_ok  = 32'(row) < MAX_DIM;
    assign elem_ok = 32'(elem) < E;
    assign tgt_ok  = 32'(tgt) < SPN;
    assign sp_rd   = (off == OFF_SP) && !pwrite_i;
    assign unused_ok = ^paddr_i;

    // Access legality for the transfer currently on the bus.
    always_comb begin
        acc_err = 1'b0;
        case (off)
            OFF_CTRL:     acc_err = pwrite_i && busy_q;
            OFF_A, OFF_B: acc_err = !row_ok || (pwrite_i && busy_q);
            OFF_FLAG:     acc_err = pwrite_i;
            OFF_SP:       acc_err = pwrite_i || !elem_ok || !tgt_ok;
            default:      acc_err = 1'b1;
        endcase
    end

    // Read mux; out-of-range indices simply match nothing and return zero.
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL: rd_data = BW'(ctrl_q);
            OFF_A: begin
                for (int r = 0; r < MAX_DIM; r++)
                    if (32'(row) == r) rd_data = a_q[r];
            end
            OFF_B: begin
                for (int r = 0; r < MAX_DIM; r++)
                    if (32'(row) == r) rd_data = b_q[r];
            end
            OFF_FLAG: rd_data = BW'(flags_q);
            OFF_SP: begin
                for (int t = 0; t < SPN; t++)
                    for (int e = 0; e < E; e++)
                        if (32'(tgt) == t && 32'(elem) == e) rd_data = sp_q[t][e];
            end
            default: rd_data = '0;
        endcase
    end

    // Errors and writes never return data.
    assign rsp_data = (acc_err || pwrite_i) ? '0 : rd_data;

    // APB handshake: response registered on entry to ACCESS, or one cycle later for scratchpad reads.
    always_comb begin
        apb_d     = apb_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (apb_q)
            S_IDLE: begin
                if (psel_i && !penable_i) apb_d = S_SETUP;
            end
            S_SETUP: begin
                apb_d = S_ACCESS;
                if (!sp_rd) begin
                    pready_d  = 1'b1;
                    pslverr_d = acc_err;
                    prdata_d  = rsp_data;
                end
            end
            S_ACCESS: begin
                if (pready_q || !(psel_i && penable_i)) begin
                    apb_d = S_IDLE;
                end else begin
                    pready_d  = 1'b1;
                    pslverr_d = acc_err;
                    prdata_d  = rsp_data;
                end
            end
            default: apb_d = S_IDLE;
        endcase
    end

    // Writes land only at the end of an error-free pready cycle.
    assign wr_commit = (apb_q == S_ACCESS) && pready_q && !pslverr_q &&
                       psel_i && penable_i && pwrite_i;
    assign ctrl_we   = wr_commit && (off == OFF_CTRL);
    assign a_we      = wr_commit && (off == OFF_A);
    assign b_we      = wr_commit && (off == OFF_B);

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
        apb_mat_row_wr #(.DW(DW), .MAX_DIM(MAX_DIM)) u_a (
            .old_i  (a_q[r]),
            .wdata_i(pwdata_i),
            .strb_i (pstrb_i),
            .we_i   (a_we && (32'(row) == r)),
            .new_o  (a_d[r])
        );
        apb_mat_row_wr #(.DW(DW), .MAX_DIM(MAX_DIM)) u_b (
            .old_i  (b_q[r]),
            .wdata_i(pwdata_i),
            .strb_i (pstrb_i),
            .we_i   (b_we && (32'(row) == r)),
            .new_o  (b_d[r])
        );
    end

    // Engine sequence: start, wait for done, drain results into the scratchpad.
    always_comb begin
        eng_d    = eng_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        of_cap_d = of_cap_q;
        flags_d  = flags_q;
        sp_d     = sp_q;
        ctrl_d   = ctrl_q;
        if (ctrl_we) ctrl_d = pwdata_i[15:0];
        case (eng_q)
            S_IDLE: begin
                if (ctrl_we && pwdata_i[0]) begin
                    eng_d  = S_OPERATE;
                    busy_d = 1'b1;
                end
            end
            S_OPERATE: begin
                if (done_i) begin
                    res_d    = result_i;
                    of_cap_d = of_i;
                    cnt_d    = '0;
                    eng_d    = S_SAVE;
                end
            end
            S_SAVE: begin
                for (int t = 0; t < SPN; t++)
                    for (int e = 0; e < E; e++)
                        if (32'(ctrl_q[3:2]) == t && 32'(cnt_q) == e) sp_d[t][e] = res_q[e];
                if (32'(cnt_q) == E - 1) begin
                    flags_d   = of_cap_q;
                    ctrl_d[0] = 1'b0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    eng_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: eng_d = S_IDLE;
        endcase
    end

    // Operand C comes from the selected scratchpad target only when enabled.
    always_comb begin
        c_sel = '0;
        if (ctrl_q[1])
            for (int t = 0; t < SPN; t++)
                if (32'(ctrl_q[5:4]) == t) c_sel = sp_q[t];
    end

    // APB state and registered response.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            apb_q     <= S_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            apb_q     <= apb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Register file and engine state; reset aborts any sequence in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            eng_q    <= S_IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            of_cap_q <= '0;
            flags_q  <= '0;
            sp_q     <= '0;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            eng_q    <= eng_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            of_cap_q <= of_cap_d;
            flags_q  <= flags_d;
            sp_q     <= sp_d;
            ctrl_q   <= ctrl_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign pready_o      = pready_q;
    assign pslverr_o     = pslverr_q;
    assign prdata_o      = prdata_q;
    assign operand_A_o   = a_q;
    assign operand_B_o   = b_q;
    assign operand_C_o   = c_sel;
    assign control_reg_o = ctrl_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_apb_mat_slave.sv
// Directed bench for apb_mat_slave: a default instance (4x4 of 8-bit lanes)
// and a 2x2, two-target instance sharing the same bus stimulus.
module tb_apb_mat_slave;
    logic         clk, rst_n;
    logic         psel, penable, pwrite, done;
    logic [3:0]   pstrb;
    logic [31:0]  pwdata;
    logic [15:0]  paddr;
    logic [15:0]  of;
    logic [511:0] result;

    logic         pready, pslverr, busy;
    logic [31:0]  prdata;
    logic [127:0] opA, opB;
    logic [511:0] opC;
    logic [15:0]  ctrl;

    logic         pready2, pslverr2, busy2;
    logic [31:0]  prdata2;
    logic [63:0]  opA2, opB2;
    logic [127:0] opC2;
    logic [15:0]  ctrl2;

    int           errors, nchk;
    logic [31:0]  rd, rd2;
    logic         er, er2, ra, r2;
    int           wt, bcnt;

    apb_mat_slave dut (
        .clk_i(clk), .reset_ni(rst_n), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .pstrb_i(pstrb), .pwdata_i(pwdata), .paddr_i(paddr),
        .pready_o(pready), .pslverr_o(pslverr), .prdata_o(prdata),
        .done_i(done), .of_i(of), .result_i(result),
        .operand_A_o(opA), .operand_B_o(opB), .operand_C_o(opC),
        .control_reg_o(ctrl), .busy_o(busy)
    );

    apb_mat_slave #(.DW(16), .BW(32), .ADDR_W(16), .SPN(2)) dut2 (
        .clk_i(clk), .reset_ni(rst_n), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .pstrb_i(pstrb[1:0]), .pwdata_i(pwdata), .paddr_i(paddr),
        .pready_o(pready2), .pslverr_o(pslverr2), .prdata_o(prdata2),
        .done_i(done), .of_i(of[3:0]), .result_i(result[127:0]),
        .operand_A_o(opA2), .operand_B_o(opB2), .operand_C_o(opC2),
        .control_reg_o(ctrl2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nchk++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; captures response of both instances at dut's pready cycle.
    task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] st);
        logic got;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        got = 1'b0; wt = 0; rd = '0; er = 1'b0; rd2 = '0; er2 = 1'b0; r2 = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (pready) begin
                got = 1'b1; rd = prdata; er = pslverr; rd2 = prdata2; er2 = pslverr2; r2 = pready2;
            end else begin
                wt++;
            end
        end
        if (!got) begin
            nchk++; errors++;
            $error("FAIL apb_timeout: addr=%0h no pready within bound", addr);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        ra = pready;
    endtask

    // Pulse done and count cycles busy stays high afterwards (bounded).
    task automatic pulse_done();
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            else break;
        end
    endtask

    initial begin
        errors = 0; nchk = 0;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; done = 1'b0;
        pstrb = '0; pwdata = '0; paddr = '0; of = '0; result = '0;
        repeat (3) @(negedge clk);
        chk("rst_apb", {pready, pslverr, prdata}, '0);
        chk("rst_ops", {opA, opB, ctrl, busy}, '0);
        chk("rst_opc", opC, '0);
        chk("rst_dut2", {pready2, pslverr2, prdata2, opA2, opB2, opC2, ctrl2, busy2}, '0);
        rst_n = 1'b1;

        // done outside OPERATE is ignored
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        @(negedge clk);
        chk("done_idle", busy, 1'b0);

        // strobed row write
        apb(1'b1, 16'h0024, 32'h04030201, 4'b0101);
        chk("a_wr_err", er, 1'b0);
        chk("a_wr_wait", wt, 1);
        chk("a_wr_rdy_once", ra, 1'b0);
        chk("a_row1", opA, 128'h0000_0000_0000_0000_0003_0001_0000_0000);
        apb(1'b0, 16'h0024, 32'h0, 4'h0);
        chk("a_rd", {er, rd}, {1'b0, 32'h00030001});
        apb(1'b1, 16'h0048, 32'hDEADBEEF, 4'hF);
        chk("b_row2", opB, {32'h0, 32'hDEADBEEF, 64'h0});

        // control upper bits read back
        apb(1'b1, 16'h0000, 32'h0000A5C8, 4'hF);
        apb(1'b0, 16'h0000, 32'h0, 4'h0);
        chk("ctrl_rd", {er, rd}, {1'b0, 32'h0000A5C8});

        // error responses
        apb(1'b0, 16'h0014, 32'h0, 4'h0);
        chk("off14", {er, rd}, {1'b1, 32'h0});
        apb(1'b1, 16'h000C, 32'hFFFF, 4'hF);
        chk("flag_wr", er, 1'b1);
        apb(1'b1, 16'h0010, 32'h1234, 4'hF);
        chk("sp_wr", er, 1'b1);
        apb(1'b0, 16'h0064, 32'h0, 4'h0);
        chk("d2_row3", {r2, er2, rd2}, {1'b1, 1'b1, 32'h0});
        chk("d1_row3", {er, rd}, {1'b0, 32'h0});
        apb(1'b0, 16'h0610, 32'h0, 4'h0);
        chk("d2_tgt3", {er2, rd2}, {1'b1, 32'h0});
        chk("sp_wait", wt, 2);

        // run with target 2, result k = k+1, of = 9
        for (int k = 0; k < 16; k++) result[k*32 +: 32] = 32'(k + 1);
        of = 16'h0009;
        apb(1'b1, 16'h0000, 32'h00000009, 4'hF);
        chk("start_busy", {busy, ctrl}, {1'b1, 16'h0009});
        apb(1'b1, 16'h0048, 32'h11111111, 4'hF);
        chk("b_busy_err", er, 1'b1);
        chk("b_busy_keep", opB, {32'h0, 32'hDEADBEEF, 64'h0});
        apb(1'b0, 16'h0000, 32'h0, 4'h0);
        chk("ctrl_rd_busy", {er, rd}, {1'b0, 32'h00000009});
        apb(1'b0, 16'h000C, 32'h0, 4'h0);
        chk("flag_rd_busy", {er, rd}, {1'b0, 32'h0});
        pulse_done();
        chk("busy_len", bcnt, 16);
        apb(1'b0, 16'h04B0, 32'h0, 4'h0);
        chk("sp_t2_e5", {er, rd, wt}, {1'b0, 32'd6, 32'd2});
        apb(1'b0, 16'h05F0, 32'h0, 4'h0);
        chk("sp_t2_e15", {er, rd}, {1'b0, 32'd16});
        apb(1'b0, 16'h000C, 32'h0, 4'h0);
        chk("flags", {er, rd}, {1'b0, 32'h00000009});
        apb(1'b0, 16'h0000, 32'h0, 4'h0);
        chk("ctrl_done", {er, rd}, {1'b0, 32'h00000008});
        apb(1'b1, 16'h0000, 32'h0000002A, 4'hF);
        chk("opc_sel", opC, result);
        apb(1'b1, 16'h0000, 32'h00000008, 4'hF);
        chk("opc_off", opC, '0);

        // reset in the middle of SAVE (k = 3), target 1
        for (int k = 0; k < 16; k++) result[k*32 +: 32] = 32'h100 + 32'(k);
        of = 16'h00F0;
        apb(1'b1, 16'h0000, 32'h00000005, 4'hF);
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_apb", {pready, pslverr, prdata}, '0);
        chk("rstmid_ops", {opA, opB, ctrl, busy}, '0);
        chk("rstmid_opc", opC, '0);
        rst_n = 1'b1;
        apb(1'b0, 16'h000C, 32'h0, 4'h0);
        chk("rstmid_flags", {er, rd}, {1'b0, 32'h0});
        apb(1'b0, 16'h0210, 32'h0, 4'h0);
        chk("rstmid_sp", {er, rd}, {1'b0, 32'h0});

        // a fresh start completes normally
        apb(1'b1, 16'h0000, 32'h00000005, 4'hF);
        chk("restart_busy", busy, 1'b1);
        pulse_done();
        chk("busy_len2", bcnt, 16);
        apb(1'b0, 16'h000C, 32'h0, 4'h0);
        chk("flags2", {er, rd}, {1'b0, 32'h000000F0});
        apb(1'b0, 16'h0270, 32'h0, 4'h0);
        chk("sp_t1_e3", {er, rd}, {1'b0, 32'h00000103});

        $display("Result: errors=%0d of %0d checks", errors, nchk);
        $finish;
    end
endmodule
